// File: rtl/pipe_pkg.sv
// Shared types for valid/ready pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/skid_pipe_reg64_enabled_ff.sv
// Single-bit D flip-flop with load enable and synchronous active-high reset.
module enableD_FF (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_pipe_reg64.sv
// Handshaked pipeline stage with a 2-entry skid; in_ready and out_valid come from state only,
// so neither side sees a combinational path from the other.
module skid_pipe_reg64
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q, main_d;
    logic             in_fire, out_fire;
    logic             main_load, skid_load, main_from_skid;

    // Output decode; the unused encoding reads as empty.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = 2'd0;
        case (state_q)
            PIPE_BUSY: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            PIPE_FULL: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                occupancy = 2'd2;
            end
            default: ;
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Data registers hold their contents across a flush.
    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        state_d        = PIPE_EMPTY;
        case (state_q)
            PIPE_EMPTY: begin
                main_load = in_fire;
                state_d   = in_fire ? PIPE_BUSY : PIPE_EMPTY;
            end
            PIPE_BUSY: begin
                main_load = in_fire & out_fire;
                skid_load = in_fire & ~out_fire;
                if (in_fire & ~out_fire) begin
                    state_d = PIPE_FULL;
                end else if (~in_fire & out_fire) begin
                    state_d = PIPE_EMPTY;
                end else begin
                    state_d = PIPE_BUSY;
                end
            end
            PIPE_FULL: begin
                main_load      = out_fire;
                main_from_skid = 1'b1;
                state_d        = out_fire ? PIPE_BUSY : PIPE_FULL;
            end
            default: state_d = PIPE_EMPTY;
        endcase
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
            state_d   = PIPE_EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PIPE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        enableD_FF u_main_ff (
            .clk   (clk),
            .reset (reset),
            .en    (main_load),
            .d     (main_d[i]),
            .q     (main_q[i])
        );
        enableD_FF u_skid_ff (
            .clk   (clk),
            .reset (reset),
            .en    (skid_load),
            .d     (in_data[i]),
            .q     (skid_q[i])
        );
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_skid_pipe_reg64.sv
// Bench for skid_pipe_reg64: queue-based model checked every cycle plus directed literal checks.
module tb_skid_pipe_reg64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = 64'h0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: entries held in order; out_data reads 0 after reset until the first accepted push.
    logic [63:0] mdl_q[$];
    bit          mdl_known = 1'b0;
    bit          mdl_zero  = 1'b0;

    always #5 clk = ~clk;

    skid_pipe_reg64 #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit rdy, ov, in_f, out_f;
        if (reset) begin
            mdl_q.delete();
            mdl_known = 1'b1;
            mdl_zero  = 1'b1;
        end else if (mdl_known) begin
            rdy   = mdl_q.size() < 2;
            ov    = mdl_q.size() > 0;
            in_f  = in_valid & rdy;
            out_f = ov & out_ready;
            if (out_f) void'(mdl_q.pop_front());
            if (flush) begin
                mdl_q.delete();
            end else if (in_f) begin
                mdl_q.push_back(in_data);
                mdl_zero = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_known) begin
            check("model_out_valid", 64'(out_valid), 64'(mdl_q.size() > 0));
            check("model_in_ready", 64'(in_ready), 64'(mdl_q.size() < 2));
            check("model_occupancy", 64'(occupancy), 64'(mdl_q.size()));
            if (mdl_q.size() > 0) check("model_out_data", out_data, mdl_q[0]);
            else if (mdl_zero) check("model_out_data_zero", out_data, 64'h0);
        end
    end

    // Apply inputs for one cycle, return at the following negedge.
    task automatic drive(input logic v, input logic [63:0] d, input logic ordy,
                         input logic fl, input logic rst);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_state(input string name, input logic ov, input logic ir,
                                input logic [1:0] occ, input logic [63:0] d);
        check({name, "_out_valid"}, 64'(out_valid), 64'(ov));
        check({name, "_in_ready"}, 64'(in_ready), 64'(ir));
        check({name, "_occupancy"}, 64'(occupancy), 64'(occ));
        check({name, "_out_data"}, out_data, d);
    endtask

    initial begin
        logic        pend_v;
        logic [63:0] pend_d;
        logic        pre_rdy;

        // 1: reset
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        expect_state("reset", 1'b0, 1'b1, 2'd0, 64'h0);

        // 2: streaming at full throughput
        drive(1'b1, 64'h1F, 1'b1, 1'b0, 1'b0);
        expect_state("stream1", 1'b1, 1'b1, 2'd1, 64'h1F);
        drive(1'b1, 64'h2A, 1'b1, 1'b0, 1'b0);
        expect_state("stream2", 1'b1, 1'b1, 2'd1, 64'h2A);
        drive(1'b1, 64'h3B, 1'b1, 1'b0, 1'b0);
        expect_state("stream3", 1'b1, 1'b1, 2'd1, 64'h3B);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        expect_state("stream_drain", 1'b0, 1'b1, 2'd0, 64'h3B);

        // 3: back-pressure fills the skid, held input not accepted
        drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        expect_state("bp_a", 1'b1, 1'b1, 2'd1, 64'hA);
        drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        expect_state("bp_full", 1'b1, 1'b0, 2'd2, 64'hA);
        drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
        expect_state("bp_hold", 1'b1, 1'b0, 2'd2, 64'hA);
        drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
        expect_state("bp_out_a", 1'b1, 1'b1, 2'd1, 64'hB);
        drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
        expect_state("bp_out_b", 1'b1, 1'b1, 2'd1, 64'hC);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        expect_state("bp_out_c", 1'b0, 1'b1, 2'd0, 64'hC);

        // 4: flush while full drops the concurrent push
        drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hD, 1'b0, 1'b1, 1'b0);
        expect_state("flush", 1'b0, 1'b1, 2'd0, 64'hA);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        expect_state("flush_after", 1'b0, 1'b1, 2'd0, 64'hA);

        // 5: reset mid-stream while full
        drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h33, 1'b0, 1'b0, 1'b1);
        expect_state("midreset", 1'b0, 1'b1, 2'd0, 64'h0);
        drive(1'b1, 64'h44, 1'b1, 1'b0, 1'b0);
        expect_state("post_reset", 1'b1, 1'b1, 2'd1, 64'h44);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // 6: random traffic; producer holds data until accepted
        pend_v = 1'b0;
        pend_d = 64'h0;
        for (int i = 0; i < 1000; i++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend_d = {$urandom, $urandom};
            end
            in_valid  = pend_v;
            in_data   = pend_d;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            reset     = 1'b0;
            pre_rdy   = in_ready;
            #1 out_ready = ~out_ready;
            #1 check("in_ready_vs_out_ready", 64'(in_ready), 64'(pre_rdy));
            out_ready = ~out_ready;
            if (pend_v && in_ready) pend_v = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
